// File: rtl/control_unit_pkg.sv
// Shared types and constants for the instruction sequencer: opcodes, FSM states,
// ALU select codes and instruction field positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_LOAD  = 4'h0,
    OP_STORE = 4'h1,
    OP_ADD   = 4'h2,
    OP_SUB   = 4'h3,
    OP_NOOP  = 4'h4,
    OP_HALT  = 4'h5
  } opcode_t;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD_A = 4'd3,
    S_LOAD_B = 4'd4,
    S_STORE  = 4'd5,
    S_ADD    = 4'd6,
    S_SUB    = 4'd7,
    S_NOOP   = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  localparam int OP_MSB      = 15;
  localparam int OP_LSB      = 12;
  localparam int RA_MSB      = 11;
  localparam int RA_LSB      = 8;
  localparam int RB_MSB      = 7;
  localparam int RB_LSB      = 4;
  localparam int RD_MSB      = 3;
  localparam int RD_LSB      = 0;
  localparam int LD_ADDR_MSB = 11;
  localparam int LD_ADDR_LSB = 4;
  localparam int ST_ADDR_MSB = 7;
  localparam int ST_ADDR_LSB = 0;

  function automatic logic [1:0] alu_op(input opcode_t op);
    case (op)
      OP_ADD:  alu_op = ALU_ADD;
      OP_SUB:  alu_op = ALU_SUB;
      default: alu_op = ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bus between the sequencer (master) and the ROM / register-file /
// data-memory datapath (slave).
interface control_unit_if #(
  parameter int PC_W     = 7,
  parameter int D_ADDR_W = 8
);
  logic [15:0]         instr_data;
  logic [PC_W-1:0]     PC_addr;
  logic                D_W_en;
  logic [D_ADDR_W-1:0] D_addr;
  logic                RF_W_en;
  logic [3:0]          RF_W_addr;
  logic [3:0]          RF_Ra_addr;
  logic [3:0]          RF_Rb_addr;
  logic                RF_s;
  logic [1:0]          ALU_s0;
  logic                halted;
  logic [3:0]          state_o;

  modport master (
    input  instr_data,
    output PC_addr, D_W_en, D_addr, RF_W_en, RF_W_addr, RF_Ra_addr,
           RF_Rb_addr, RF_s, ALU_s0, halted, state_o
  );

  modport slave (
    output instr_data,
    input  PC_addr, D_W_en, D_addr, RF_W_en, RF_W_addr, RF_Ra_addr,
           RF_Rb_addr, RF_s, ALU_s0, halted, state_o
  );
endinterface

// File: rtl/control_unit_decoder.sv
// Splits the instruction register into opcode and operand fields; the data
// address comes from a different bit range for LOAD than for STORE.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output opcode_t     opcode,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [3:0]  rd,
  output logic [7:0]  addr
);

  assign opcode = opcode_t'(ir[OP_MSB:OP_LSB]);
  assign ra     = ir[RA_MSB:RA_LSB];
  assign rb     = ir[RB_MSB:RB_LSB];
  assign rd     = ir[RD_MSB:RD_LSB];
  assign addr   = (opcode == OP_LOAD) ? ir[LD_ADDR_MSB:LD_ADDR_LSB]
                                      : ir[ST_ADDR_MSB:ST_ADDR_LSB];

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer: owns PC, IR and the FSM and
// drives every datapath control line combinationally from state and IR.
module control_unit
  import cpu_pkg::*;
#(
  parameter int PC_W     = 7,
  parameter int D_ADDR_W = 8
) (
  input logic            clk,
  input logic            reset_n,
  control_unit_if.master bus
);

  state_t          state;
  state_t          next_state;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;

  opcode_t    ir_op;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rd;
  logic [7:0] addr;

  instr_decoder u_decoder (
    .ir     (ir),
    .opcode (ir_op),
    .ra     (ra),
    .rb     (rb),
    .rd     (rd),
    .addr   (addr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_INIT;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (state == S_INIT) begin
        pc <= '0;
        ir <= '0;
      end else if (state == S_DECODE) begin
        ir <= bus.instr_data;
        pc <= pc + PC_W'(1);
      end
    end
  end

  // Dispatch looks at the ROM word directly because IR only loads at the end of DECODE.
  always_comb begin
    next_state     = state;
    bus.D_W_en     = 1'b0;
    bus.D_addr     = '0;
    bus.RF_W_en    = 1'b0;
    bus.RF_W_addr  = '0;
    bus.RF_Ra_addr = '0;
    bus.RF_Rb_addr = '0;
    bus.RF_s       = 1'b0;
    bus.ALU_s0     = ALU_PASS;
    bus.halted     = 1'b0;
    case (state)
      S_INIT:   next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (opcode_t'(bus.instr_data[OP_MSB:OP_LSB]))
          OP_LOAD:  next_state = S_LOAD_A;
          OP_STORE: next_state = S_STORE;
          OP_ADD:   next_state = S_ADD;
          OP_SUB:   next_state = S_SUB;
          OP_HALT:  next_state = S_HALT;
          default:  next_state = S_NOOP;
        endcase
      end
      S_LOAD_A, S_LOAD_B: begin
        bus.D_addr    = D_ADDR_W'(addr);
        bus.RF_W_addr = rd;
        bus.RF_s      = 1'b1;
        bus.RF_W_en   = (state == S_LOAD_B);
        next_state    = (state == S_LOAD_A) ? S_LOAD_B : S_FETCH;
      end
      S_STORE: begin
        bus.RF_Ra_addr = ra;
        bus.D_addr     = D_ADDR_W'(addr);
        bus.D_W_en     = 1'b1;
        next_state     = S_FETCH;
      end
      S_ADD, S_SUB: begin
        bus.RF_Ra_addr = ra;
        bus.RF_Rb_addr = rb;
        bus.RF_W_addr  = rd;
        bus.RF_W_en    = 1'b1;
        bus.ALU_s0     = alu_op(ir_op);
        next_state     = S_FETCH;
      end
      S_NOOP:   next_state = S_FETCH;
      S_HALT: begin
        bus.halted = 1'b1;
        next_state = S_HALT;
      end
      default:  next_state = S_INIT;
    endcase
  end

  assign bus.PC_addr = pc;
  assign bus.state_o = state;

endmodule
